muldiv_iter: RTL

- Parametrised iterative multiply/divide unit for the EX stage, successor to the fixed 32-bit divider.
- Supports signed and unsigned multiply and divide at configurable WIDTH. Results are produced as a HI/LO pair.
- Provides a start/busy/done handshake so the hazard unit can stall EX while busy.
- Provides a cancel input so an exception flush kills an in-flight operation.

---
 rtl/muldiv_iter_if.sv | 27 ++
 rtl/muldiv_iter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
//   master : issues start/op/a/b and cancel (flush); observes busy/done/results
//   slave  : the muldiv_iter unit itself
interface muldiv_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;        // 00 mult, 01 multu, 10 div, 11 divu
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, div_zero, result_hi, result_lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, div_zero, result_hi, result_lo
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply and divide unit with a start/busy/done handshake.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : muldiv_iter_if slave
//          start/op/a/b sampled only in IDLE; cancel aborts RUN/FIX
//          busy while RUN/FIX; done one-cycle pulse with result_hi/result_lo/div_zero
// Multiply: radix-2 shift-add on a 2*WIDTH accumulator, WIDTH iterations.
// Divide: restoring division, one quotient bit per cycle, MSB first.
// Signed ops run on magnitudes and are sign-corrected in FIX.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input logic          clk,
  input logic          rst,
  muldiv_iter_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               neg_quo_q, neg_quo_d;  // negate product / quotient
  logic               neg_rem_q, neg_rem_d;  // negate remainder
  logic [WIDTH-1:0]   b_q, b_d;
  // Multiply: {hi, lo} partial product. Divide: low half shifts dividend out, quotient in.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;

  // Operand conditioning in IDLE; the most-negative value maps onto itself as unsigned.
  logic             in_signed;
  logic [WIDTH-1:0] a_abs, b_abs;
  assign in_signed = ~bus.op[0];
  assign a_abs     = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_abs     = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // One multiply step: add b into the upper half on lsb, then shift right with carry.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};

  // One restoring-divide step on the WIDTH+1 bit shifted remainder.
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  assign rem_sh   = {rem_q, acc_q[WIDTH-1]};
  assign div_ge   = rem_sh >= {1'b0, b_q};
  assign div_diff = rem_sh[WIDTH-1:0] - b_q;  // exact whenever div_ge

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_quo_q ? -acc_q : acc_q;
  assign quo_fix  = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    b_d        = b_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    res_hi_d   = res_hi_q;
    res_lo_d   = res_lo_q;

    case (state_q)
      StIdle: begin
        if (bus.start && !bus.cancel) begin
          op_d       = bus.op;
          cnt_d      = '0;
          neg_quo_d  = in_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_rem_d  = in_signed & bus.a[WIDTH-1];
          b_d        = b_abs;
          rem_d      = '0;
          div_zero_d = 1'b0;
          if (bus.op[1] && (bus.b == '0)) begin
            // Raw dividend kept so FIX can return it uncorrected in result_hi.
            acc_d   = {{WIDTH{1'b0}}, bus.a};
            state_d = StFix;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, a_abs};
            state_d = StRun;
          end
        end
      end

      StRun: begin
        if (bus.cancel) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (op_q[1]) begin
            rem_d = div_ge ? div_diff : rem_sh[WIDTH-1:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = StFix;
          end
        end
      end

      StFix: begin
        state_d = StIdle;
        if (!bus.cancel) begin
          done_d = 1'b1;
          if (op_q[1]) begin
            if (b_q == '0) begin
              res_lo_d   = '1;
              res_hi_d   = acc_q[WIDTH-1:0];
              div_zero_d = 1'b1;
            end else begin
              res_lo_d = quo_fix;
              res_hi_d = rem_fix;
            end
          end else begin
            res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
            res_lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      b_q        <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      res_hi_q   <= res_hi_d;
      res_lo_q   <= res_lo_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.result_hi = res_hi_q;
  assign bus.result_lo = res_lo_q;

endmodule
